// File: rtl/accl_pair_scheduler.sv
// accl_pair_scheduler: issues all ordered body pairs (i,j), i!=j, into a fixed-latency
// acceleration pipeline and tags each result for the per-body accumulator.
module accl_pair_scheduler #(
    parameter int IDX_W    = 9,
    parameter int PIPE_LAT = 90
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   n_bodies,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] rd_addr_i,
    output logic [IDX_W-1:0] rd_addr_j,
    output logic             pipe_valid,
    output logic             acc_valid,
    output logic [IDX_W-1:0] acc_idx,
    output logic             acc_first,
    output logic             acc_last
);
    localparam int CW = $clog2(PIPE_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state;
    logic [IDX_W:0] n_lat;
    logic issue;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PIPE_LAT:0] tag_v, tag_f, tag_l;
    logic [PIPE_LAT:0][IDX_W-1:0] tag_i;
    logic [IDX_W:0] iw, jw, j1, j2, nm1, nm2;
    logic cur_first, cur_last, wrap, last_pair;
    // Stage 0 of the tag line is the store-output stage, so pipe_valid is tag_v[0].
    assign pipe_valid = tag_v[0];
    assign acc_valid  = tag_v[PIPE_LAT];
    assign acc_idx    = tag_i[PIPE_LAT];
    assign acc_first  = tag_f[PIPE_LAT];
    assign acc_last   = tag_l[PIPE_LAT];
    // Index arithmetic is one bit wider so N = 2^IDX_W compares correctly.
    always_comb begin
        iw        = {1'b0, rd_addr_i};
        jw        = {1'b0, rd_addr_j};
        nm1       = n_lat - 1'b1;
        nm2       = n_lat - 2'd2;
        j1        = jw + 1'b1;
        j2        = (j1 == iw) ? jw + 2'd2 : j1;
        wrap      = j2 >= n_lat;
        cur_first = jw == (IDX_W+1)'(iw == '0);
        cur_last  = jw == ((iw == nm1) ? nm2 : nm1);
        last_pair = cur_last && (iw == nm1);
        cnt_nxt   = cnt + CW'(pipe_valid) - CW'(acc_valid);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            n_lat     <= '0;
            issue     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_addr_i <= '0;
            rd_addr_j <= '0;
            tag_v     <= '0;
            tag_f     <= '0;
            tag_l     <= '0;
            tag_i     <= '0;
        end else begin
            tag_v <= {tag_v[PIPE_LAT-1:0], issue};
            tag_f <= {tag_f[PIPE_LAT-1:0], issue & cur_first};
            tag_l <= {tag_l[PIPE_LAT-1:0], issue & cur_last};
            tag_i <= {tag_i[PIPE_LAT-1:0], rd_addr_i};
            cnt   <= cnt_nxt;
            done  <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                issue <= 1'b0;
                tag_v <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        n_lat <= n_bodies;
                        if (n_bodies < (IDX_W+1)'(2)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            busy      <= 1'b1;
                            issue     <= 1'b1;
                            rd_addr_i <= '0;
                            rd_addr_j <= IDX_W'(1);
                        end
                    end
                    ISSUE: if (last_pair) begin
                        state <= DRAIN;
                        issue <= 1'b0;
                    end else begin
                        rd_addr_i <= wrap ? rd_addr_i + 1'b1 : rd_addr_i;
                        rd_addr_j <= wrap ? '0 : j2[IDX_W-1:0];
                    end
                    DRAIN: if (cnt_nxt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    DONE: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_accl_pair_scheduler.sv
// tb_accl_pair_scheduler: random and directed runs checked every cycle against a
// per-cycle expectation timeline built from the pair enumeration rules.
module tb_accl_pair_scheduler;
    localparam int IW = 3;
    localparam int L  = 4;
    localparam int NC = 4000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [IW:0] n_bodies = '0;
    logic busy, done, pipe_valid, acc_valid, acc_first, acc_last;
    logic [IW-1:0] rd_addr_i, rd_addr_j, acc_idx;
    bit e_rd[NC], e_pv[NC], e_av[NC], e_af[NC], e_al[NC], e_busy[NC], e_done[NC];
    int e_ri[NC], e_rj[NC], e_ai[NC];
    int cyc = 0, idle_at = 0, tests = 0, fails = 0;

    always #5 clk = ~clk;

    accl_pair_scheduler #(.IDX_W(IW), .PIPE_LAT(L)) dut (
        .clk(clk), .rst(rst), .start(start), .n_bodies(n_bodies), .abort(abort),
        .busy(busy), .done(done), .rd_addr_i(rd_addr_i), .rd_addr_j(rd_addr_j),
        .pipe_valid(pipe_valid), .acc_valid(acc_valid), .acc_idx(acc_idx),
        .acc_first(acc_first), .acc_last(acc_last)
    );

    task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, a, e);
        end
    endtask

    task automatic clear_from(input int c);
        for (int k = c; k < NC; k++) begin
            e_rd[k] = 0; e_pv[k] = 0; e_av[k] = 0; e_af[k] = 0; e_al[k] = 0;
            e_busy[k] = 0; e_done[k] = 0; e_ri[k] = 0; e_rj[k] = 0; e_ai[k] = 0;
        end
    endtask

    // Pairs are enumerated in i-major order; the k-th pair is issued at s+1+k.
    task automatic schedule(input int s, input int n);
        int k = 0;
        if (n < 2) begin
            e_done[s+1] = 1;
            idle_at = s + 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            int m = 0;
            for (int j = 0; j < n; j++) if (j != i) begin
                int c = s + 1 + k;
                e_rd[c] = 1; e_ri[c] = i; e_rj[c] = j;
                e_pv[c+1] = 1;
                e_av[c+1+L] = 1; e_ai[c+1+L] = i;
                e_af[c+1+L] = (m == 0);
                e_al[c+1+L] = (m == n - 2);
                m++; k++;
            end
        end
        for (int c = s + 1; c <= s + 1 + L + k; c++) e_busy[c] = 1;
        e_done[s+2+L+k] = 1;
        idle_at = s + 3 + L + k;
    endtask

    task automatic check(input int c);
        cmp("busy", busy, e_busy[c]);
        cmp("done", done, e_done[c]);
        cmp("pipe_valid", pipe_valid, e_pv[c]);
        cmp("acc_valid", acc_valid, e_av[c]);
        if (e_rd[c]) begin
            cmp("rd_addr_i", rd_addr_i, e_ri[c]);
            cmp("rd_addr_j", rd_addr_j, e_rj[c]);
        end
        if (e_av[c]) begin
            cmp("acc_idx", acc_idx, e_ai[c]);
            cmp("acc_first", acc_first, e_af[c]);
            cmp("acc_last", acc_last, e_al[c]);
        end
    endtask

    task automatic tick(input bit st, input int n, input bit ab, input bit rs);
        @(negedge clk);
        rst = 1'b0;
        check(cyc);
        start = st;
        n_bodies = n[IW:0];
        abort = ab;
        if (rs) begin
            rst = 1'b1;
            #1;
            cmp("rst_busy", busy, 0);
            cmp("rst_done", done, 0);
            cmp("rst_pipe_valid", pipe_valid, 0);
            cmp("rst_acc_valid", acc_valid, 0);
            cmp("rst_acc_first", acc_first, 0);
            cmp("rst_acc_last", acc_last, 0);
            cmp("rst_addrs", {rd_addr_i, rd_addr_j, acc_idx}, 0);
            clear_from(cyc + 1);
            idle_at = cyc + 1;
        end else if (ab) begin
            clear_from(cyc + 1);
            idle_at = cyc + 1;
        end else if (st && cyc >= idle_at) begin
            schedule(cyc, n);
        end
        cyc++;
    endtask

    // Hand-derived N=3, PIPE_LAT=4 timeline pins the model itself.
    task automatic pin_model(input int s);
        int pi[6] = '{0, 0, 1, 1, 2, 2};
        int pj[6] = '{1, 2, 0, 2, 0, 1};
        for (int k = 0; k < 6; k++) begin
            cmp("pin_pair", {e_rd[s+1+k], 8'(e_ri[s+1+k]), 8'(e_rj[s+1+k])}, {1'b1, 8'(pi[k]), 8'(pj[k])});
            cmp("pin_acc", {e_av[s+6+k], 8'(e_ai[s+6+k]), e_af[s+6+k], e_al[s+6+k]},
                {1'b1, 8'(pi[k]), k % 2 == 0, k % 2 == 1});
        end
        cmp("pin_pv", {e_pv[s+1], e_pv[s+2], e_pv[s+7], e_pv[s+8]}, 4'b0110);
        cmp("pin_busy", {e_busy[s], e_busy[s+1], e_busy[s+11], e_busy[s+12]}, 4'b0110);
        cmp("pin_done", {e_done[s+11], e_done[s+12], e_done[s+13]}, 3'b010);
    endtask

    initial begin
        int s;
        clear_from(0);
        tick(0, 0, 0, 1);
        repeat (2) tick(0, 0, 0, 0);
        s = cyc;
        tick(1, 3, 0, 0);
        pin_model(s);
        repeat (14) tick(0, 0, 0, 0);
        tick(1, 2, 0, 0);
        repeat (12) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0);
        tick(1, 1, 0, 0);
        repeat (3) tick(0, 0, 0, 0);
        // Abort two cycles into DRAIN with three results in flight, then restart.
        s = cyc;
        tick(1, 3, 0, 0);
        repeat (8) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        tick(1, 2, 0, 0);
        repeat (14) tick(0, 0, 0, 0);
        // Full-size run with ignored start pulses.
        tick(1, 8, 0, 0);
        repeat (20) tick($urandom_range(0, 1), $urandom_range(0, 8), 0, 0);
        repeat (50) tick(0, 0, 0, 0);
        // Asynchronous reset in the middle of ISSUE, then a normal run.
        tick(1, 4, 0, 0);
        repeat (3) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(1, 3, 0, 0);
        repeat (20) tick(0, 0, 0, 0);
        repeat (2500)
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 8),
                 $urandom_range(0, 199) == 0, $urandom_range(0, 499) == 0);
        repeat (80) tick(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
